// File: rtl/fu_mul_pipe_if.sv
// Issue-side and result-side handshake bundle for the pipelined multiply FU.
// slave is the FU view, master is the issue/consumer view.
interface fu_mul_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag,
    output out_ready,
    input  in_ready, out_valid, out_res, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag,
    input  out_ready,
    output in_ready, out_valid, out_res, out_tag
  );
endinterface

// File: rtl/fu_mul_pipe.sv
// Fully pipelined RV32M multiply FU (MUL/MULH/MULHSU/MULHU) with tag and flush.
// FU_MUL_OCC_EN adds the occ port counting valid ops held in the pipe.
module fu_mul_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  parameter int TAG_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  fu_mul_pipe_if.slave bus
`ifdef FU_MUL_OCC_EN
  ,
  output logic [$clog2(LATENCY+2)-1:0] occ
`endif
);

  logic stall;
  logic acc;

  assign stall = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign acc = bus.in_valid & ~stall & ~flush;

  logic             sa;
  logic             sb;
  logic [WIDTH:0]   ea;
  logic [WIDTH:0]   eb;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_d;

  // Only the low 2*WIDTH bits of the (2*WIDTH+2)-bit product are ever used.
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (1'b1)
      (bus.in_op == 2'b01): begin
        sa = 1'b1;
        sb = 1'b1;
      end
      (bus.in_op == 2'b10): sa = 1'b1;
      default: ;
    endcase
    ea = {sa & bus.in_a[WIDTH-1], bus.in_a};
    eb = {sb & bus.in_b[WIDTH-1], bus.in_b};
    prod = {{(WIDTH-1){ea[WIDTH]}}, ea}
         * {{(WIDTH-1){eb[WIDTH]}}, eb};
    res_d = (bus.in_op == 2'b00)
          ? prod[WIDTH-1:0]
          : prod[2*WIDTH-1:WIDTH];
  end

  logic [LATENCY-1:0] vld;
  logic [WIDTH-1:0]   res_q [LATENCY];
  logic [TAG_W-1:0]   tag_q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else if (!stall) begin
      vld[0]   <= acc;
      res_q[0] <= res_d;
      tag_q[0] <= bus.in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i]   <= vld[i-1];
        res_q[i] <= res_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign bus.out_valid = vld[LATENCY-1];
  assign bus.out_res   = res_q[LATENCY-1];
  assign bus.out_tag   = tag_q[LATENCY-1];

`ifdef FU_MUL_OCC_EN
  localparam int OW = $clog2(LATENCY+2);

  logic take;

  assign take = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      occ <= occ + OW'(acc) - OW'(take);
    end
  end
`endif

endmodule
